apb_master: RTL and testbench
=============================

# apb_master

APB requester that turns single-beat host commands into APB SETUP/ACCESS transfers, and drives the APB slave port (`psel`/`penable`/`pwrite`/`paddr`/`pwdata`) directly. It collects `prdata`/`pready`/`pslvrr` and returns one response per command. It adds a bounded wait-state timeout so a hung slave cannot stall the host. It sits directly upstream of `apb_slave` on the same `pclk` domain.

## Interface
Parameters:
- `ADDR_W`, 32, APB address width.
- `DATA_W`, 32, APB data width.
- `TIMEOUT`, 16, maximum ACCESS cycles without `pready`; 0 disables the timeout.

Ports:
- `pclk`  in  1  clock; one clock for the whole block.
- `preset`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and aborted transfers.
- `rsp_err`  out  1  slave error or timeout.
- `rsp_timeout`  out  1  transfer aborted by timeout.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  APB read data.
- `pready`  in  1  slave ready.
- `pslvrr`  in  1  slave error, valid with `pready`.

## Operation
- FSM has three states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- `cmd_ready` = (state == IDLE) and is combinational from state. It is 1 in reset.
- IDLE: on accept, register `paddr`/`pwrite`/`pwdata`, set `psel`=1, and go to SETUP. For a read, `pwdata` holds its previous value.
- SETUP: `psel`=1, `penable`=0. Go to ACCESS unconditionally and clear the wait counter.
- ACCESS: `psel`=1, `penable`=1.
  - Edge with `pready`=1: completion.
    - Drop `psel`/`penable` and go to IDLE.
    - Pulse `rsp_valid` for exactly one cycle.
    - `rsp_err` = `pslvrr`.
    - `rsp_rdata` = `prdata` if read and `pslvrr`=0, else 0.
    - `rsp_timeout` = 0.
  - Edge with `pready`=0: the wait counter increments.
  - Timeout: if `TIMEOUT`≠0 and the counter has reached `TIMEOUT-1`, abort.
    - Drop `psel`/`penable` and go to IDLE.
    - Pulse `rsp_valid` with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
  - If `pready` and the timeout fall on the same edge, `pready` wins and the transfer completes normally.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the end of ACCESS. They keep their last values in IDLE.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` hold until the next response.
- The wait counter is wide enough for `TIMEOUT-1` (clog2, minimum 1 bit). It saturates and never wraps.
- Reset values: `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0, wait counter = 0.
- Reset mid-transfer, in any state: at the next edge all outputs take their reset values and the FSM goes to IDLE. No response is issued for the in-flight command.

## Timing
- A command is accepted at edge E0, sampled in IDLE.
  - SETUP is visible after E0.
  - ACCESS (`penable`=1) is visible after E1.
  - If `pready`=1 at E2, `rsp_valid` is high for the cycle after E2.
- Minimum latency is 3 edges from accept to the response cycle. Each wait state adds 1 edge.
- `cmd_ready` returns to 1 in the same cycle as `rsp_valid`. The next command can therefore be accepted at E3, giving a minimum transfer period of 3 cycles.
- A timeout abort happens after exactly `TIMEOUT` ACCESS cycles with `pready`=0. For `TIMEOUT`=4, the abort edge is E5 and `rsp_valid` is high after E5.
- `cmd_*` inputs are sampled only at the accept edge. Changes at other times have no effect.

## Test plan
- Write with zero wait states: `cmd_addr`=0x00, `cmd_wdata`=0xDEADBEEF, `pready`=1.
  - Required: `psel`=1 and `penable`=0 for one cycle, then `penable`=1 for one cycle.
  - Required: `rsp_valid` pulse at E2+1 with `rsp_err`=0 and `rsp_rdata`=0.
- Read with 2 wait states: `pready` low for 2 ACCESS cycles, `prdata`=0xDEADBEEF.
  - Required: ACCESS lasts 3 cycles and `paddr`/`pwrite` stay stable throughout.
  - Required: `rsp_rdata`=0xDEADBEEF with `rsp_valid` after E4.
- Slave error: write to 0x3F with `pready`=1 and `pslvrr`=1.
  - Required: `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- Timeout: `TIMEOUT`=4 with `pready` held at 0.
  - Required: after 4 ACCESS cycles, `psel`=`penable`=0 and the response has `rsp_err`=1, `rsp_timeout`=1.
  - Repeat with `pready`=1 on the 4th ACCESS cycle. Required: normal completion with `rsp_timeout`=0.
- Back-to-back: `cmd_valid` held high for a write then a read to 0x04.
  - Required: the second accept occurs in the `rsp_valid` cycle of the first, with one IDLE cycle between `psel` periods.
- Reset mid-ACCESS: assert `preset` for 1 cycle while `pready`=0.
  - Required: all outputs are 0 after the edge, `cmd_ready`=1, and no `rsp_valid`.
  - Required: the next command completes normally.

Source files
------------

// File: rtl/apb_master_if.sv
// apb_master_if: APB bus between a requester and a completer
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic pready;
  logic pslvrr;
  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslvrr
  );
  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslvrr
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-beat host commands to APB transfers, with a wait-state timeout
module apb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic rsp_err,
  output logic rsp_timeout,
  apb_master_if.master apb
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic rsp_err_q, rsp_err_d;
  logic rsp_timeout_q, rsp_timeout_d;
  logic accept, done, abort;
  always_comb begin
    accept = state_q == IDLE && cmd_valid;
    done = state_q == ACCESS && apb.pready;
    abort = state_q == ACCESS && !apb.pready && TIMEOUT != 0 && cnt_q == CNT_LAST;
    state_d = accept ? SETUP : state_q == SETUP ? ACCESS : (done || abort) ? IDLE : state_q;
    psel_d = accept || (psel_q && !(done || abort));
    penable_d = state_q == SETUP || (penable_q && !(done || abort));
    pwrite_d = accept ? cmd_write : pwrite_q;
    paddr_d = accept ? cmd_addr : paddr_q;
    pwdata_d = (accept && cmd_write) ? cmd_wdata : pwdata_q;
    cnt_d = state_q == SETUP ? '0 :
            (state_q == ACCESS && !apb.pready && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    rsp_valid_d = done || abort;
    rsp_err_d = done ? apb.pslvrr : abort ? 1'b1 : rsp_err_q;
    rsp_timeout_d = (done || abort) ? abort : rsp_timeout_q;
    rsp_rdata_d = done ? ((!pwrite_q && !apb.pslvrr) ? apb.prdata : '0) :
                  abort ? '0 : rsp_rdata_q;
  end
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q <= '0;
      pwdata_q <= '0;
      cnt_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      pwrite_q <= pwrite_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      cnt_q <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign apb.psel = psel_q;
  assign apb.penable = penable_q;
  assign apb.pwrite = pwrite_q;
  assign apb.paddr = paddr_q;
  assign apb.pwdata = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed scenario checks for apb_master with a 4-cycle timeout
module tb_apb_master;
  logic pclk;
  logic preset;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  logic rsp_timeout;
  logic [3:0] ctl;
  logic [2:0] rsp;
  int checks;
  int failures;
  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .pclk(pclk),
    .preset(preset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .apb(bus.master)
  );
  assign ctl = {cmd_ready, bus.psel, bus.penable, bus.pwrite};
  assign rsp = {rsp_valid, rsp_err, rsp_timeout};
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic test_reset();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
    checks++;
    if (ctl !== 4'b1000 || bus.paddr !== 32'h0 || bus.pwdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_ctl ctl=%b paddr=%h pwdata=%h want ctl=1000 paddr=0 pwdata=0", ctl, bus.paddr, bus.pwdata);
    end
    checks++;
    if (rsp !== 3'b000 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp rsp=%b rdata=%h want rsp=000 rdata=0", rsp, rsp_rdata);
    end
  endtask
  task automatic test_write_zero_wait();
    bus.pready = 1'b1;
    issue(1'b1, 32'h0, 32'hDEADBEEF);
    checks++;
    if (ctl !== 4'b0101 || bus.paddr !== 32'h0 || bus.pwdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_setup ctl=%b paddr=%h pwdata=%h want ctl=0101 paddr=0 pwdata=deadbeef", ctl, bus.paddr, bus.pwdata);
    end
    tick();
    checks++;
    if (ctl !== 4'b0111 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL wr_access ctl=%b rsp_valid=%b want ctl=0111 rsp_valid=0", ctl, rsp_valid);
    end
    tick();
    checks++;
    if (ctl !== 4'b1001 || rsp !== 3'b100 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_rsp ctl=%b rsp=%b rdata=%h want ctl=1001 rsp=100 rdata=0", ctl, rsp, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp !== 3'b000 || ctl !== 4'b1001) begin
      failures++;
      $display("FAIL wr_pulse rsp=%b ctl=%b want rsp=000 ctl=1001", rsp, ctl);
    end
  endtask
  task automatic test_read_wait2();
    bus.pready = 1'b0;
    bus.prdata = 32'hDEADBEEF;
    issue(1'b0, 32'h10, 32'h12345678);
    checks++;
    if (ctl !== 4'b0100 || bus.paddr !== 32'h10 || bus.pwdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_setup ctl=%b paddr=%h pwdata=%h want ctl=0100 paddr=10 pwdata=deadbeef", ctl, bus.paddr, bus.pwdata);
    end
    cmd_addr = 32'hFFFF_0000;
    cmd_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl !== 4'b0110 || bus.paddr !== 32'h10 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rd_access%0d ctl=%b paddr=%h rsp_valid=%b want ctl=0110 paddr=10 rsp_valid=0", i, ctl, bus.paddr, rsp_valid);
      end
      if (i == 2) bus.pready = 1'b1;
    end
    tick();
    checks++;
    if (rsp !== 3'b100 || rsp_rdata !== 32'hDEADBEEF || ctl !== 4'b1000) begin
      failures++;
      $display("FAIL rd_rsp rsp=%b rdata=%h ctl=%b want rsp=100 rdata=deadbeef ctl=1000", rsp, rsp_rdata, ctl);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_hold rsp_valid=%b rdata=%h want rsp_valid=0 rdata=deadbeef", rsp_valid, rsp_rdata);
    end
  endtask
  task automatic test_slave_err();
    bus.pready = 1'b1;
    bus.pslvrr = 1'b1;
    issue(1'b1, 32'h3F, 32'h55);
    tick();
    tick();
    checks++;
    if (rsp !== 3'b110 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL err_wr rsp=%b rdata=%h want rsp=110 rdata=0", rsp, rsp_rdata);
    end
    bus.prdata = 32'h1234ABCD;
    issue(1'b0, 32'h3F, 32'h0);
    tick();
    tick();
    checks++;
    if (rsp !== 3'b110 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL err_rd rsp=%b rdata=%h want rsp=110 rdata=0", rsp, rsp_rdata);
    end
    bus.pslvrr = 1'b0;
  endtask
  task automatic test_timeout();
    bus.pready = 1'b0;
    bus.prdata = 32'hCAFEF00D;
    issue(1'b0, 32'h20, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ctl !== 4'b0110 || rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL to_wait%0d ctl=%b rsp_valid=%b want ctl=0110 rsp_valid=0", i, ctl, rsp_valid);
      end
    end
    tick();
    checks++;
    if (ctl !== 4'b1000 || rsp !== 3'b111 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL to_abort ctl=%b rsp=%b rdata=%h want ctl=1000 rsp=111 rdata=0", ctl, rsp, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp !== 3'b011) begin
      failures++;
      $display("FAIL to_hold rsp=%b want 011", rsp);
    end
    issue(1'b0, 32'h24, 32'h0);
    tick();
    tick();
    tick();
    tick();
    bus.pready = 1'b1;
    checks++;
    if (ctl !== 4'b0110 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL to_edge_wait ctl=%b rsp_valid=%b want ctl=0110 rsp_valid=0", ctl, rsp_valid);
    end
    tick();
    checks++;
    if (rsp !== 3'b100 || rsp_rdata !== 32'hCAFEF00D || ctl !== 4'b1000) begin
      failures++;
      $display("FAIL to_edge_done rsp=%b rdata=%h ctl=%b want rsp=100 rdata=cafef00d ctl=1000", rsp, rsp_rdata, ctl);
    end
  endtask
  task automatic test_back_to_back();
    bus.pready = 1'b1;
    bus.prdata = 32'h0BADF00D;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h04;
    cmd_wdata = 32'hA5A5A5A5;
    tick();
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    tick();
    tick();
    checks++;
    if (ctl !== 4'b1001 || rsp !== 3'b100 || bus.pwdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_rsp1 ctl=%b rsp=%b pwdata=%h want ctl=1001 rsp=100 pwdata=a5a5a5a5", ctl, rsp, bus.pwdata);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (ctl !== 4'b0100 || bus.paddr !== 32'h04 || rsp_valid !== 1'b0 || bus.pwdata !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL b2b_accept2 ctl=%b paddr=%h rsp_valid=%b pwdata=%h want ctl=0100 paddr=4 rsp_valid=0 pwdata=a5a5a5a5", ctl, bus.paddr, rsp_valid, bus.pwdata);
    end
    tick();
    tick();
    checks++;
    if (rsp !== 3'b100 || rsp_rdata !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL b2b_rsp2 rsp=%b rdata=%h want rsp=100 rdata=0badf00d", rsp, rsp_rdata);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    bus.pready = 1'b0;
    issue(1'b1, 32'h08, 32'h11);
    tick();
    tick();
    preset = 1'b1;
    tick();
    preset = 1'b0;
    checks++;
    if (ctl !== 4'b1000 || bus.paddr !== 32'h0 || bus.pwdata !== 32'h0 || rsp !== 3'b000 || rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_out ctl=%b paddr=%h pwdata=%h rsp=%b rdata=%h want ctl=1000 paddr=0 pwdata=0 rsp=000 rdata=0", ctl, bus.paddr, bus.pwdata, rsp, rsp_rdata);
    end
    bus.pready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || ctl !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_norsp rsp_valid=%b ctl=%b want rsp_valid=0 ctl=1000", rsp_valid, ctl);
    end
    bus.prdata = 32'h77;
    issue(1'b0, 32'h0C, 32'h0);
    tick();
    tick();
    checks++;
    if (rsp !== 3'b100 || rsp_rdata !== 32'h77 || bus.paddr !== 32'h0C) begin
      failures++;
      $display("FAIL rstmid_next rsp=%b rdata=%h paddr=%h want rsp=100 rdata=77 paddr=c", rsp, rsp_rdata, bus.paddr);
    end
  endtask
  initial begin
    checks = 0;
    failures = 0;
    preset = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = 32'h0;
    cmd_wdata = 32'h0;
    bus.prdata = 32'h0;
    bus.pready = 1'b0;
    bus.pslvrr = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait2();
    test_slave_err();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
